// File: rtl/hex_out_pkg.sv
// Shared constants and types for the six-digit hex display driver.
package hex_out_pkg;

  localparam int NUM_DIGITS = 6;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 (F) first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Blink phase: visible is the reset / idle phase.
  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/hex_out_seg7_dec.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7_dec
  import hex_out_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/hex_out.sv
// Six-digit hex display driver: buffered writes committed on a refresh
// tick, optional leading-zero blanking and blinking, registered outputs.
//
// Write handshake: WE is a one-cycle strobe with no back-pressure; WDATA is
// captured on every edge where WE=1 and the last write before a tick wins.
// BUSY is high while a captured value waits for the next tick. ACK pulses
// for one cycle right after the tick that moves it onto the display.
module hex_out
  import hex_out_pkg::*;
#(
  parameter int TICK_DIV    = 1250000,
  parameter int BLINK_TICKS = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WE,
  input  logic [23:0] WDATA,
  input  logic        BLANKZ,
  input  logic        BLINK,
  output logic        BUSY,
  output logic        ACK,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]   presc_q;
  logic            tick;
  logic [23:0]     pend_q;
  logic            pend_valid_q;
  logic [23:0]     disp_q;
  logic            ack_q;
  logic [7:0]      blink_cnt_q;
  blink_phase_e    phase_q;
  logic            out_live_q;
  logic            commit;
  logic [5:0]      blank;
  logic [6:0]      seg [NUM_DIGITS];
  logic [6:0]      hex_q [NUM_DIGITS];

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign commit = tick && pend_valid_q;

  // Refresh prescaler: free-running 0..TICK_DIV-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Pending write buffer; a write on the commit tick re-arms it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else if (WE) begin
      pend_q       <= WDATA;
      pend_valid_q <= 1'b1;
    end else if (commit) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Display register and the commit acknowledge pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      disp_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= commit;
      if (commit) begin
        disp_q <= pend_q;
      end
    end
  end

  // Blink timing: count ticks, flip phase on wrap, park when disabled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blink_cnt_q <= '0;
      phase_q     <= PHASE_VISIBLE;
    end else if (!BLINK) begin
      blink_cnt_q <= '0;
      phase_q     <= PHASE_VISIBLE;
    end else if (tick) begin
      if (blink_cnt_q == 8'(BLINK_TICKS - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end else begin
        blink_cnt_q <= blink_cnt_q + 8'd1;
      end
    end
  end

  // Output enable: keeps the outputs dark for the first edge after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_live_q <= 1'b0;
    end else begin
      out_live_q <= 1'b1;
    end
  end

  // Leading-zero blanking: walk down from digit 5 while digits stay zero.
  always_comb begin
    logic run_zero;
    blank    = '0;
    run_zero = 1'b1;
    for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
      run_zero = run_zero && (disp_q[4*n +: 4] == 4'h0);
      blank[n] = BLANKZ && run_zero;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .digit (disp_q[4*g +: 4]),
      .seg   (seg[g])
    );
  end

  // Registered segment outputs with blink and blanking applied.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        hex_q[n] <= SEG_OFF;
      end
    end else begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (!out_live_q || (BLINK && (phase_q == PHASE_HIDDEN)) || blank[n]) begin
          hex_q[n] <= SEG_OFF;
        end else begin
          hex_q[n] <= seg[n];
        end
      end
    end
  end

  assign BUSY = pend_valid_q;
  assign ACK  = ack_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule
